// File: rtl/comport_pkg.sv
// Shared definitions for the COM-port responder.
//   - register indices (A[10:8] of the $F8EF..$FFEF window)
//   - LSR bit positions and IIR codes
//   - serial FSM state enum and a packed struct holding both FSM states,
//     which is also the observation point for the TX and RX state machines.
package comport_pkg;

  localparam logic [2:0] REG_RBR_THR = 3'd0;
  localparam logic [2:0] REG_IER     = 3'd1;
  localparam logic [2:0] REG_IIR_FCR = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;
  localparam logic [2:0] REG_MCR     = 3'd4;
  localparam logic [2:0] REG_LSR     = 3'd5;
  localparam logic [2:0] REG_MSR     = 3'd6;
  localparam logic [2:0] REG_SCR     = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam logic [7:0] IIR_RDA   = 8'hC4;
  localparam logic [7:0] IIR_THRE  = 8'hC2;
  localparam logic [7:0] IIR_NONE  = 8'hC1;
  localparam logic [7:0] MSR_VALUE = 8'hB0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_t;

  typedef struct packed {
    ser_state_t tx;
    ser_state_t rx;
  } fsm_state_t;

endpackage

// File: rtl/comport_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write (ignored when full)
//   pop        : read  (ignored when empty); dout always shows the head entry
//   flush      : empties the FIFO, overriding a same-cycle push/pop
//   full, empty: status
module comport_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         wr;
  logic         rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/comport_uart.sv
// Z80 COM-port responder: 16550-subset register file plus 8N1 UART.
//   clk, rst_n                  : clock, async active-low reset
//   wait_start/rnw/addr/wdata   : one-cycle request from the port decoder
//   wait_rdata, wait_end        : read data and one-cycle completion pulse
//   rxd, txd                    : serial line (txd idles high)
//   irq                         : registered interrupt request
//
// Handshake: wait_start is accepted only when idle (req_q and wait_end low).
// The request is latched on that edge (cycle 0), the register access and all
// its side effects happen on the next edge (cycle 1), and wait_end is high for
// exactly cycle 2. wait_rdata is updated by reads only and holds until the
// next read completes.
module comport_uart
  import comport_pkg::*;
#(
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] DIV_RESET = 16'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wait_start,
  input  logic       wait_rnw,
  input  logic [2:0] wait_addr,
  input  logic [7:0] wait_wdata,
  output logic [7:0] wait_rdata,
  output logic       wait_end,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  logic       req_q, req_rnw;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic [1:0] ier;
  logic [7:0] lcr, mcr, scr, dll, dlm, lsr, iir, rd_mux;
  logic       oe, fe, dlab, acc_rd, acc_wr;
  logic       dr, thre, temt;
  logic       rx_pop, rx_flush, rx_empty, rx_full, rx_push;
  logic       tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic [7:0] rx_dout, tx_dout;
  logic [15:0] baud_cnt, div;
  logic       tick;
  logic [1:0] rx_sync;
  logic       rx_in, tx_line;

  fsm_state_t st, st_n;
  logic [3:0] tx_tcnt, tx_tcnt_n, rx_tcnt, rx_tcnt_n;
  logic [2:0] tx_bcnt, tx_bcnt_n, rx_bcnt, rx_bcnt_n;
  logic [7:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n;

  // ---------------- request capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      req_rnw   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      wait_end  <= 1'b0;
    end else begin
      req_q    <= wait_start && !req_q && !wait_end;
      wait_end <= req_q;
      if (wait_start && !req_q && !wait_end) begin
        req_rnw   <= wait_rnw;
        req_addr  <= wait_addr;
        req_wdata <= wait_wdata;
      end
    end
  end

  assign dlab     = lcr[7];
  assign acc_rd   = req_q && req_rnw;
  assign acc_wr   = req_q && !req_rnw;
  assign rx_pop   = acc_rd && (req_addr == REG_RBR_THR) && !dlab;
  assign tx_push  = acc_wr && (req_addr == REG_RBR_THR) && !dlab && !tx_full;
  assign rx_flush = acc_wr && (req_addr == REG_IIR_FCR) && req_wdata[1];
  assign tx_flush = acc_wr && (req_addr == REG_IIR_FCR) && req_wdata[2];

  assign dr   = !rx_empty;
  assign thre = tx_empty;
  assign temt = tx_empty && (st.tx == ST_IDLE);

  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = dr;
    lsr[LSR_OE]   = oe;
    lsr[LSR_FE]   = fe;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = temt;
    if (ier[0] && dr)        iir = IIR_RDA;
    else if (ier[1] && thre) iir = IIR_THRE;
    else                     iir = IIR_NONE;
    case (req_addr)
      REG_RBR_THR: rd_mux = dlab ? dll : (rx_empty ? 8'h00 : rx_dout);
      REG_IER:     rd_mux = dlab ? dlm : {6'b0, ier};
      REG_IIR_FCR: rd_mux = iir;
      REG_LCR:     rd_mux = lcr;
      REG_MCR:     rd_mux = mcr;
      REG_LSR:     rd_mux = lsr;
      REG_MSR:     rd_mux = MSR_VALUE;
      default:     rd_mux = scr;
    endcase
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier        <= '0;
      lcr        <= '0;
      mcr        <= '0;
      scr        <= '0;
      {dlm, dll} <= DIV_RESET;
      oe         <= 1'b0;
      fe         <= 1'b0;
      wait_rdata <= '0;
      irq        <= 1'b0;
    end else begin
      if (acc_wr) begin
        case (req_addr)
          REG_RBR_THR: if (dlab) dll <= req_wdata;
          REG_IER:     if (dlab) dlm <= req_wdata; else ier <= req_wdata[1:0];
          REG_LCR:     lcr <= req_wdata;
          REG_MCR:     mcr <= req_wdata;
          REG_SCR:     scr <= req_wdata;
          default:     ;
        endcase
      end
      if (acc_rd) wait_rdata <= rd_mux;
      // A new error in the same cycle as an LSR read must not be lost.
      if (rx_push && rx_full)                   oe <= 1'b1;
      else if (acc_rd && req_addr == REG_LSR)   oe <= 1'b0;
      if (rx_push && !rx_in)                    fe <= 1'b1;
      else if (acc_rd && req_addr == REG_LSR)   fe <= 1'b0;
      irq <= (ier[0] && dr) || (ier[1] && thre);
    end
  end

  // ---------------- baud generator (16x) ----------------
  assign div  = {dlm, dll};
  assign tick = (baud_cnt == 16'd0) && (div != 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  baud_cnt <= '0;
    else if (baud_cnt == 16'd0)  baud_cnt <= (div == 16'd0) ? 16'd0 : div - 16'd1;
    else                         baud_cnt <= baud_cnt - 16'd1;
  end

  // ---------------- serial line ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rxd};
  end

  assign tx_line = (st.tx == ST_START) ? 1'b0 :
                   (st.tx == ST_DATA)  ? tx_shift[0] : 1'b1;
  // Loopback feeds the TX line straight back (already synchronous).
  assign rx_in   = mcr[4] ? tx_line : rx_sync[1];
  assign txd     = tx_line | mcr[4];

  // ---------------- TX / RX state machines ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= '{tx: ST_IDLE, rx: ST_IDLE};
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
    end else begin
      st       <= st_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bcnt  <= tx_bcnt_n;
      tx_shift <= tx_shift_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bcnt  <= rx_bcnt_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    st_n       = st;
    tx_tcnt_n  = tx_tcnt;
    tx_bcnt_n  = tx_bcnt;
    tx_shift_n = tx_shift;
    rx_tcnt_n  = rx_tcnt;
    rx_bcnt_n  = rx_bcnt;
    rx_shift_n = rx_shift;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;

    // Each non-idle TX state lasts 16 ticks; tcnt wraps 15 -> 0 on exit.
    case (st.tx)
      ST_IDLE: if (tick && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_n = tx_dout;
        tx_tcnt_n  = '0;
        st_n.tx    = ST_START;
      end
      ST_START: if (tick) begin
        tx_tcnt_n = tx_tcnt + 4'd1;
        if (tx_tcnt == 4'd15) begin
          tx_bcnt_n = '0;
          st_n.tx   = ST_DATA;
        end
      end
      ST_DATA: if (tick) begin
        tx_tcnt_n = tx_tcnt + 4'd1;
        if (tx_tcnt == 4'd15) begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bcnt_n  = tx_bcnt + 3'd1;
          if (tx_bcnt == 3'd7) st_n.tx = ST_STOP;
        end
      end
      ST_STOP: if (tick) begin
        tx_tcnt_n = tx_tcnt + 4'd1;
        if (tx_tcnt == 4'd15) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_dout;
            st_n.tx    = ST_START;
          end else begin
            st_n.tx = ST_IDLE;
          end
        end
      end
      default: st_n.tx = ST_IDLE;
    endcase

    // RX re-checks the start bit half a bit in, then samples bit centres.
    case (st.rx)
      ST_IDLE: if (tick && !rx_in) begin
        rx_tcnt_n = '0;
        st_n.rx   = ST_START;
      end
      ST_START: if (tick) begin
        rx_tcnt_n = rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd7) begin
          rx_tcnt_n = '0;
          rx_bcnt_n = '0;
          st_n.rx   = rx_in ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: if (tick) begin
        rx_tcnt_n = rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd15) begin
          rx_shift_n = {rx_in, rx_shift[7:1]};
          rx_bcnt_n  = rx_bcnt + 3'd1;
          if (rx_bcnt == 3'd7) st_n.rx = ST_STOP;
        end
      end
      ST_STOP: if (tick) begin
        rx_tcnt_n = rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd15) begin
          rx_push = 1'b1;
          st_n.rx = ST_IDLE;
        end
      end
      default: st_n.rx = ST_IDLE;
    endcase
  end

  // ---------------- FIFOs ----------------
  comport_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_shift),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  comport_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (req_wdata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

endmodule

// File: tb/tb_comport_uart.sv
// Directed bench for comport_uart: register access through the wait
// handshake, TX waveform, loopback, overrun, framing error, glitch filter,
// interrupt and TX flush.
module tb_comport_uart;
  import comport_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wait_start = 1'b0;
  logic       wait_rnw = 1'b0;
  logic [2:0] wait_addr = 3'd0;
  logic [7:0] wait_wdata = 8'h00;
  logic [7:0] wait_rdata;
  logic       wait_end;
  logic       rxd = 1'b1;
  logic       txd;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  logic lb_watch = 1'b0;
  int   lb_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  comport_uart #(.FIFO_AW(4), .DIV_RESET(16'd1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wait_start (wait_start),
    .wait_rnw   (wait_rnw),
    .wait_addr  (wait_addr),
    .wait_wdata (wait_wdata),
    .wait_rdata (wait_rdata),
    .wait_end   (wait_end),
    .rxd        (rxd),
    .txd        (txd),
    .irq        (irq)
  );

  always @(negedge clk) if (lb_watch && txd !== 1'b1) lb_bad++;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus(input logic rnw, input logic [2:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output int lat);
    @(negedge clk);
    wait_start = 1'b1;
    wait_rnw   = rnw;
    wait_addr  = addr;
    wait_wdata = wd;
    @(negedge clk);
    wait_start = 1'b0;
    lat = 1;
    while (wait_end !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = wait_rdata;
    if (wait_end !== 1'b1) check("wait_end_timeout", 16'(lat), 16'd2);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] d);
    logic [7:0] x;
    int l;
    bus(1'b0, addr, d, x, l);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    logic [7:0] x;
    int l;
    bus(1'b1, addr, 8'h00, x, l);
    check(tag, 16'(x), 16'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame on rxd at 16 clk per bit (divisor 1).
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] r;
    logic [7:0] tx_byte;
    int l;
    int found;

    rst_n = 1'b0;
    idle(3);
    check("reset_txd", 16'(txd), 16'd1);
    check("reset_irq", 16'(irq), 16'd0);
    check("reset_wait_end", 16'(wait_end), 16'd0);
    check("reset_rdata", 16'(wait_rdata), 16'h00);
    rst_n = 1'b1;
    idle(2);

    bus(1'b1, REG_LSR, 8'h00, r, l);
    check("lsr_latency", 16'(l), 16'd2);
    check("lsr_reset", 16'(r), 16'h60);
    rd_chk("iir_reset", REG_IIR_FCR, 8'hC1);
    rd_chk("msr_read", REG_MSR, 8'hB0);

    wr(REG_LCR, 8'h80);
    rd_chk("dll_reset", REG_RBR_THR, 8'h01);
    rd_chk("dlm_reset", REG_IER, 8'h00);
    rd_chk("lcr_read", REG_LCR, 8'h80);
    wr(REG_LCR, 8'h00);
    wr(REG_SCR, 8'h5A);
    rd_chk("scr_read", REG_SCR, 8'h5A);
    wr(REG_IER, 8'hFF);
    rd_chk("ier_masked", REG_IER, 8'h03);
    wr(REG_IER, 8'h00);

    // TX waveform of 8'hA5: start, LSB-first data, stop; sampled mid-bit.
    tx_byte = 8'hA5;
    exp_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(tx_byte[i]));
    exp_q.push_back(8'h01);
    wr(REG_RBR_THR, tx_byte);
    fork
      begin
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
          @(negedge clk);
          if (txd == 1'b0) found = 1;
        end
        check("tx_start_seen", 16'(found), 16'd1);
        idle(7);
        for (int k = 0; k < 10; k++) begin
          check("tx_bit", 16'(txd), 16'(exp_q.pop_front()));
          idle(16);
        end
      end
      begin
        idle(40);
        rd_chk("lsr_mid_frame", REG_LSR, 8'h20);
      end
    join
    idle(20);
    rd_chk("lsr_tx_done", REG_LSR, 8'h60);

    // Loopback: two bytes come back in order, txd held high.
    wr(REG_MCR, 8'h10);
    lb_watch = 1'b1;
    wr(REG_RBR_THR, 8'h3C);
    exp_q.push_back(8'h3C);
    wr(REG_RBR_THR, 8'hC3);
    exp_q.push_back(8'hC3);
    idle(400);
    rd_chk("lsr_lb_dr", REG_LSR, 8'h61);
    bus(1'b1, REG_RBR_THR, 8'h00, r, l);
    check("rbr_lb_first", 16'(r), 16'(exp_q.pop_front()));
    rd_chk("lsr_lb_dr_still", REG_LSR, 8'h61);
    bus(1'b1, REG_RBR_THR, 8'h00, r, l);
    check("rbr_lb_second", 16'(r), 16'(exp_q.pop_front()));
    rd_chk("lsr_lb_empty", REG_LSR, 8'h60);

    // Loopback overrun: 17 bytes into a 16-deep RX FIFO.
    for (int i = 0; i < 17; i++) wr(REG_RBR_THR, 8'(8'h10 + i));
    idle(2900);
    rd_chk("lsr_overrun", REG_LSR, 8'h63);
    rd_chk("lsr_oe_cleared", REG_LSR, 8'h61);
    rd_chk("rbr_oldest", REG_RBR_THR, 8'h10);
    wr(REG_IIR_FCR, 8'h02);
    rd_chk("lsr_rx_flushed", REG_LSR, 8'h60);
    rd_chk("rbr_empty", REG_RBR_THR, 8'h00);
    lb_watch = 1'b0;
    check("lb_txd_high", 16'(lb_bad), 16'd0);
    wr(REG_MCR, 8'h00);

    // External frame with a bad stop bit.
    send_rx(8'h55, 1'b0);
    idle(30);
    rd_chk("lsr_fe", REG_LSR, 8'h69);
    rd_chk("rbr_ext", REG_RBR_THR, 8'h55);
    rd_chk("lsr_fe_cleared", REG_LSR, 8'h60);

    // Short low glitch is not a start bit.
    @(negedge clk);
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    rd_chk("lsr_glitch", REG_LSR, 8'h60);

    // Interrupts.
    wr(REG_IER, 8'h01);
    idle(2);
    check("irq_quiet", 16'(irq), 16'd0);
    send_rx(8'h96, 1'b1);
    idle(30);
    check("irq_rx", 16'(irq), 16'd1);
    rd_chk("iir_rda", REG_IIR_FCR, 8'hC4);
    rd_chk("rbr_irq", REG_RBR_THR, 8'h96);
    idle(2);
    check("irq_cleared", 16'(irq), 16'd0);
    wr(REG_IER, 8'h02);
    idle(2);
    check("irq_thre", 16'(irq), 16'd1);
    rd_chk("iir_thre", REG_IIR_FCR, 8'hC2);
    wr(REG_IER, 8'h00);

    // TX flush with the FIFO full and the shifter busy.
    for (int i = 0; i < 17; i++) wr(REG_RBR_THR, 8'(i));
    rd_chk("lsr_tx_full", REG_LSR, 8'h00);
    wr(REG_IIR_FCR, 8'h04);
    rd_chk("lsr_tx_flushed", REG_LSR, 8'h20);
    idle(200);
    rd_chk("lsr_tx_drained", REG_LSR, 8'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
